// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: funct3 size encodings,
// FSM state enum, byte-enable constants and small decode helpers.
package mem_pkg;

    // funct3 size/sign encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-enable patterns before lane shifting
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Access FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Lane enables for a given size; halfwords use only addr[1] and words
    // ignore the offset entirely, so misaligned accesses are silently aligned.
    function automatic logic [3:0] byte_enable(input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = BE_BYTE << off;
            2'b01:   be = BE_HALF << {off[1], 1'b0};
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    // True when the access size does not fit its natural alignment
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] off);
        logic bad;
        case (f3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/halfword lane from a 32-bit read word and
// sign- or zero-extends it to XLEN according to funct3.
module load_extender
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane select by registered address offset, then extend by size/sign
    always_comb begin
        lane_b = rdata[{off, 3'b000} +: 8];
        lane_h = rdata[{off[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    ext = {{(XLEN-8){lane_b[7]}}, lane_b};
            F3_BU:   ext = {{(XLEN-8){1'b0}}, lane_b};
            F3_H:    ext = {{(XLEN-16){lane_h[15]}}, lane_h};
            F3_HU:   ext = {{(XLEN-16){1'b0}}, lane_h};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ME-stage data-memory access unit. Turns a load/store in the ME stage into a
// registered request on the dmem port, stalls the pipeline until dmem_ack, and
// presents extended load data for exactly one unstalled cycle (DONE).
// Optional feature: define MEM_MISALIGN_TRAP_EN to flag misaligned H/W accesses
// (no request issued) instead of silently aligning them.
//
// Handshake: dmem_req is held high with all dmem_* fields stable from the first
// BUSY cycle until the cycle dmem_ack is sampled high; the request completes on
// that edge and dmem_ack is ignored in every other state.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_M,
    input  logic            mem_rd_M,
    input  logic            mem_wr_M,
    input  logic [2:0]      funct3_M,
    input  logic [XLEN-1:0] addr_M,
    input  logic [XLEN-1:0] wdata_M,
    output logic            stall_M,
    output logic [XLEN-1:0] Rdata_ext_M,
    output logic            misalign_M,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output mem_state_e      state_dbg
);

    mem_state_e      state;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic            access;
    logic            misalign_c;
    logic            start;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] ext_data;

    // Access decode, misalignment detection and combinational stall
    always_comb begin
        access = valid_M & (mem_rd_M | mem_wr_M);
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_c = access & (state == ST_IDLE) & is_misaligned(funct3_M, addr_M[1:0]);
`else
        misalign_c = 1'b0;
`endif
        start   = access & ~misalign_c & (state == ST_IDLE);
        stall_M = (state == ST_BUSY) | start;
    end

    assign misalign_M = rst_n & misalign_c;
    assign state_dbg  = state;

    // Store data replicated across every lane the size could target
    always_comb begin
        case (funct3_M[1:0])
            2'b00:   wdata_rep = {(XLEN/8){wdata_M[7:0]}};
            2'b01:   wdata_rep = {(XLEN/16){wdata_M[15:0]}};
            default: wdata_rep = wdata_M;
        endcase
    end

    load_extender #(.XLEN(XLEN)) u_load_extender (
        .funct3 (funct3_q),
        .off    (off_q),
        .rdata  (dmem_rdata),
        .ext    (ext_data)
    );

    // Access FSM with registered dmem port and load result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= '0;
            dmem_wdata  <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            Rdata_ext_M <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_wr_M;
                        dmem_addr  <= {addr_M[XLEN-1:2], 2'b00};
                        dmem_be    <= byte_enable(funct3_M, addr_M[1:0]);
                        dmem_wdata <= wdata_rep;
                        funct3_q   <= funct3_M;
                        off_q      <= addr_M[1:0];
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            Rdata_ext_M <= ext_data;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
